latch_bank_ctrl: RTL and testbench

Write controller and arbiter for a bank of level-sensitive `d_latch` registers that hold FPU operands. It accepts write requests from two requesters (A: external load path, B: FPU result writeback) and grants one at a time. For each granted write it drives the bank's shared data bus and one-hot latch enables through a glitch-free setup / enable / hold sequence. It sits between the FPU control logic and the latch bank.

---
 rtl/latch_bank_ctrl.sv | 94 +++++++++
 tb/tb_latch_bank_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/latch_bank_ctrl.sv
// latch_bank_ctrl: arbitrated setup/enable/hold write sequencer for a bank of level-sensitive latches.
// Define LATCH_BANK_RR_EN for round-robin arbitration; otherwise requester B has fixed priority.
module latch_bank_ctrl #(
    parameter int WIDTH     = 8,
    parameter int NREG      = 4,
    parameter int ADDR_W    = 2,
    parameter int PULSE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [WIDTH-1:0]  a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [WIDTH-1:0]  b_data,
    output logic [WIDTH-1:0]  latch_d,
    output logic [NREG-1:0]   latch_en,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [NREG-1:0] en_q, en_d;
    logic grant_b;
`ifdef LATCH_BANK_RR_EN
    logic rr_q, rr_d;
    assign grant_b = b_valid && (!a_valid || rr_q);
`else
    assign grant_b = b_valid;
`endif
    assign a_ready  = !rst && state_q == IDLE && a_valid && !grant_b;
    assign b_ready  = !rst && state_q == IDLE && grant_b;
    assign latch_d  = data_q;
    assign latch_en = en_q;
    assign busy     = state_q != IDLE;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        en_d    = '0;
`ifdef LATCH_BANK_RR_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            IDLE: if (a_ready || b_ready) begin
                state_d = SETUP;
                addr_d  = grant_b ? b_addr : a_addr;
                data_d  = grant_b ? b_data : a_data;
`ifdef LATCH_BANK_RR_EN
                rr_d    = !grant_b;
`endif
            end
            SETUP: begin
                state_d = PULSE;
                cnt_d   = 4'(PULSE_CYC);
                // an out-of-range address matches no bit, so the bank stays untouched
                for (int i = 0; i < NREG; i++) en_d[i] = addr_q == ADDR_W'(i);
            end
            PULSE: begin
                state_d = cnt_q == 4'd1 ? HOLD : PULSE;
                cnt_d   = cnt_q - 4'd1;
                en_d    = cnt_q == 4'd1 ? '0 : en_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            en_q    <= '0;
`ifdef LATCH_BANK_RR_EN
            rr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            en_q    <= en_d;
`ifdef LATCH_BANK_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end
endmodule

// File: tb/tb_latch_bank_ctrl.sv
// tb_latch_bank_ctrl: directed and randomized checks against a cycles-since-handshake reference model.
module tb_latch_bank_ctrl;
    localparam int W = 8, N = 3, AW = 2, P = 2;
    logic clk = 0, rst = 1, a_valid = 0, b_valid = 0;
    logic [AW-1:0] a_addr = 0, b_addr = 0;
    logic [W-1:0] a_data = 0, b_data = 0;
    logic a_ready, b_ready, busy;
    logic [W-1:0] latch_d;
    logic [N-1:0] latch_en;
    int checks = 0, errors = 0;
    int cyc = 0, t0 = -100;
    logic [W-1:0] m_d = 0;
    logic [AW-1:0] m_addr = 0;
    bit rr = 0, hs_a = 0, hs_b = 0;
    logic [W-1:0] bank [N];
    logic [W-1:0] exp_bank [N];

    latch_bank_ctrl #(.WIDTH(W), .NREG(N), .ADDR_W(AW), .PULSE_CYC(P)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .latch_d(latch_d), .latch_en(latch_en), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // one clock: compare outputs at negedge, advance the model at posedge, return 1 time unit later
    task automatic cycle();
        int k;
        logic ea, eb;
        logic [N-1:0] een;
        @(negedge clk);
        k = cyc - t0;
        ea = 0;
        eb = 0;
        if (!rst && !(k >= 1 && k <= P + 2)) begin
`ifdef LATCH_BANK_RR_EN
            if (a_valid && b_valid) begin ea = !rr; eb = rr; end
            else begin ea = a_valid; eb = b_valid; end
`else
            eb = b_valid;
            ea = a_valid && !b_valid;
`endif
        end
        een = (k >= 2 && k <= P + 1 && int'(m_addr) < N) ? N'(1) << m_addr : '0;
        chk("a_ready", a_ready, ea);
        chk("b_ready", b_ready, eb);
        chk("busy", busy, (k >= 1 && k <= P + 2) ? 1 : 0);
        chk("latch_en", latch_en, een);
        chk("latch_d", latch_d, m_d);
        for (int i = 0; i < N; i++) if (latch_en[i]) bank[i] = latch_d;
        hs_a = a_valid && ea;
        hs_b = b_valid && eb;
        @(posedge clk);
        if (rst) begin
            t0 = -100;
            m_d = 0;
            rr = 0;
        end else if (hs_a || hs_b) begin
            t0 = cyc;
            m_d = hs_b ? b_data : a_data;
            m_addr = hs_b ? b_addr : a_addr;
            rr = hs_a;
            if (int'(m_addr) < N) exp_bank[m_addr] = m_d;
        end
        cyc++;
        #1;
    endtask

    task automatic write_a(input logic [AW-1:0] addr, input logic [W-1:0] data);
        int n = 0;
        a_valid = 1;
        a_addr = addr;
        a_data = data;
        do begin cycle(); n++; end while (!hs_a && n < 50);
        chk("a_accept", hs_a, 1);
        a_valid = 0;
    endtask

    initial begin
        int bcnt;
        bit first_b, seen;
        for (int i = 0; i < N; i++) begin bank[i] = 0; exp_bank[i] = 0; end
        @(posedge clk);
        #1;
        a_valid = 1;
        a_addr = 0;
        a_data = 8'h11;
        cycle();
        cycle();
        rst = 0;
        a_valid = 0;
        cycle();
        write_a(2, 8'h5A);
        repeat (5) cycle();
        chk("bank2_single", bank[2], 8'h5A);
        a_valid = 1; a_addr = 0; a_data = 8'h33;
        b_valid = 1; b_addr = 1; b_data = 8'hC4;
        bcnt = 0;
        seen = 0;
        first_b = 0;
        for (int n = 0; n < 60 && (a_valid || b_valid); n++) begin
            cycle();
            if ((hs_a || hs_b) && !seen) begin seen = 1; first_b = hs_b; end
            if (hs_a) a_valid = 0;
            if (hs_b) begin
                bcnt++;
                b_data = 8'hC5;
                if (bcnt == 2) b_valid = 0;
            end
        end
        chk("sim_drained", {a_valid, b_valid}, 0);
`ifdef LATCH_BANK_RR_EN
        chk("first_grant_b", first_b, 0);
`else
        chk("first_grant_b", first_b, 1);
`endif
        repeat (5) cycle();
        chk("bank0_sim", bank[0], 8'h33);
        chk("bank1_sim", bank[1], 8'hC5);
        write_a(3, 8'hEE);
        repeat (5) cycle();
        write_a(1, 8'h77);
        cycle();
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        cycle();
        chk("en_after_rst", latch_en, 0);
        write_a(1, 8'h78);
        repeat (5) cycle();
        chk("bank1_after_rst", bank[1], 8'h78);
        for (int n = 0; n < 400; n++) begin
            if (!a_valid && $urandom_range(0, 2) == 0) begin
                a_valid = 1; a_addr = AW'($urandom_range(0, 3)); a_data = W'($urandom);
            end
            if (!b_valid && $urandom_range(0, 2) == 0) begin
                b_valid = 1; b_addr = AW'($urandom_range(0, 3)); b_data = W'($urandom);
            end
            cycle();
            if (hs_a) a_valid = 0;
            if (hs_b) b_valid = 0;
        end
        for (int n = 0; n < 100 && (a_valid || b_valid); n++) begin
            cycle();
            if (hs_a) a_valid = 0;
            if (hs_b) b_valid = 0;
        end
        chk("rand_drained", {a_valid, b_valid}, 0);
        repeat (6) cycle();
        for (int i = 0; i < N; i++) chk($sformatf("bank%0d_final", i), bank[i], exp_bank[i]);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
